// File: rtl/pfc_boost_ctrl.sv
// pfc_boost_ctrl: boost PFC stage controller.
// A free-running PWM counter drives a registered gate output. The duty comes
// from the latched output-voltage error, optionally plus input-voltage
// feedforward, and is ramped in by a soft-start limit. An overvoltage sample
// latches a fault that only an explicit clear can release.
// Build option: define PFC_FEEDFORWARD_EN to compile in vin feedforward.
//
// state      | meaning
// -----------+------------------------------------------------------
// IDLE  (0)  | gate off, duty 0, waiting for en
// SOFTSTART  | duty = min(cmd, limit); limit ramps by SS_STEP per period
// RUN   (2)  | duty = cmd, refreshed at every period end
// FAULT (3)  | overvoltage seen; gate off until fault_clr with safe vout
module pfc_boost_ctrl #(
    parameter int ADC_W      = 24,
    parameter int PWM_W      = 8,
    parameter int PWM_PERIOD = 200,
    parameter int V_TARGET   = 10066329,
    parameter int V_OVP      = 11744051,
    parameter int DUTY_BASE  = 80,
    parameter int DUTY_MAX   = 180,
    parameter int ERR_SHIFT  = 16,
    parameter int FF_SHIFT   = 17,
    parameter int SS_STEP    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fault_clr,
    input  logic             sample_valid,
    input  logic [ADC_W-1:0] vin_sense,
    input  logic [ADC_W-1:0] vout_sense,
    output logic             pfc_drv,
    output logic [PWM_W-1:0] duty,
    output logic             pwm_sync,
    output logic [1:0]       state,
    output logic             fault_ovp
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SOFTSTART = 2'd1,
        ST_RUN       = 2'd2,
        ST_FAULT     = 2'd3
    } state_t;

    localparam logic [PWM_W-1:0] LP_CNT_LAST   = PWM_W'(PWM_PERIOD - 1);
    localparam logic [ADC_W-1:0] LP_V_TARGET   = ADC_W'(V_TARGET);
    localparam logic [ADC_W-1:0] LP_V_OVP      = ADC_W'(V_OVP);
    localparam logic [ADC_W:0]   LP_BASE_WIDE  = (ADC_W + 1)'(DUTY_BASE);
    localparam logic [ADC_W:0]   LP_MAX_WIDE   = (ADC_W + 1)'(DUTY_MAX);
    localparam logic [PWM_W-1:0] LP_DUTY_MAX   = PWM_W'(DUTY_MAX);
    localparam logic [PWM_W:0]   LP_LIM_MAX_W  = (PWM_W + 1)'(DUTY_MAX);
    localparam logic [PWM_W:0]   LP_SS_STEP_W  = (PWM_W + 1)'(SS_STEP);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PWM_W-1:0] r_cnt;
    logic [PWM_W-1:0] r_duty;
    logic [PWM_W-1:0] r_lim;
    logic             r_drv;
    logic             r_sync;
    logic             r_fault;
    logic [ADC_W-1:0] r_vout_l;

    logic             w_period_end;
    logic [PWM_W-1:0] w_cnt_nxt;
    logic             w_ovp;
    logic [ADC_W-1:0] w_err;
    logic [ADC_W-1:0] w_ff;
    logic [ADC_W:0]   w_sum;
    logic [PWM_W-1:0] w_cmd;
    logic [PWM_W:0]   w_lim_sum;
    logic [PWM_W-1:0] w_lim_step;
    logic             w_ss_done;
    logic             w_active_nxt;
    logic [PWM_W-1:0] w_duty_nxt;
    logic [PWM_W-1:0] w_lim_nxt;
    logic             w_drv_nxt;

    assign w_period_end = (r_cnt == LP_CNT_LAST);
    assign w_cnt_nxt    = w_period_end ? '0 : r_cnt + PWM_W'(1);
    // Trip on the raw sample so the fault lands on the very next edge.
    assign w_ovp        = sample_valid && (vout_sense >= LP_V_OVP);

    assign w_err = (r_vout_l < LP_V_TARGET) ? ((LP_V_TARGET - r_vout_l) >> ERR_SHIFT) : '0;

`ifdef PFC_FEEDFORWARD_EN
    logic [ADC_W-1:0] r_vin_l;

    // Input sample latch, only needed when feedforward is built in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            r_vin_l <= '0;
        else if (sample_valid) r_vin_l <= vin_sense;
    end

    assign w_ff = (r_vin_l < LP_V_TARGET) ? ((LP_V_TARGET - r_vin_l) >> FF_SHIFT) : '0;
`else
    logic w_unused_vin;
    assign w_unused_vin = ^{vin_sense, 32'(FF_SHIFT)};
    assign w_ff         = '0;
`endif

    assign w_sum = {1'b0, w_err} + {1'b0, w_ff} + LP_BASE_WIDE;
    assign w_cmd = (w_sum > LP_MAX_WIDE) ? LP_DUTY_MAX : w_sum[PWM_W-1:0];

    // Next soft-start limit, saturating at DUTY_MAX; reaching it ends the ramp.
    assign w_lim_sum  = {1'b0, r_lim} + LP_SS_STEP_W;
    assign w_lim_step = (w_lim_sum >= LP_LIM_MAX_W) ? LP_DUTY_MAX : w_lim_sum[PWM_W-1:0];
    assign w_ss_done  = (w_lim_step == LP_DUTY_MAX);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; overvoltage overrides every other request.
    always_comb begin
        w_state_nxt = r_state;
        if (w_ovp) begin
            w_state_nxt = ST_FAULT;
        end else begin
            case (r_state)
                ST_IDLE:      if (en) w_state_nxt = ST_SOFTSTART;
                ST_SOFTSTART: begin
                    if (!en)                           w_state_nxt = ST_IDLE;
                    else if (w_period_end && w_ss_done) w_state_nxt = ST_RUN;
                end
                ST_RUN:       if (!en) w_state_nxt = ST_IDLE;
                ST_FAULT:     if (fault_clr && (r_vout_l < LP_V_OVP)) w_state_nxt = ST_IDLE;
                default:      w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output decode: duty/limit/gate values for the coming cycle.
    always_comb begin
        w_active_nxt = (w_state_nxt == ST_SOFTSTART) || (w_state_nxt == ST_RUN);

        w_duty_nxt = r_duty;
        if (!w_active_nxt) begin
            w_duty_nxt = '0;
        end else if (w_period_end && (r_state != ST_IDLE)) begin
            // Entering from IDLE keeps duty 0 until the first full period ends.
            if (w_state_nxt == ST_RUN)  w_duty_nxt = w_cmd;
            else if (w_cmd < w_lim_step) w_duty_nxt = w_cmd;
            else                         w_duty_nxt = w_lim_step;
        end

        w_lim_nxt = r_lim;
        if (!w_active_nxt || (r_state == ST_IDLE))            w_lim_nxt = '0;
        else if ((r_state == ST_SOFTSTART) && w_period_end)   w_lim_nxt = w_lim_step;

        // Compare against next-cycle counter so the gate lines up with r_cnt.
        w_drv_nxt = w_active_nxt && (w_cnt_nxt < w_duty_nxt);
    end

    // PWM counter, datapath registers and sample latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_duty   <= '0;
            r_lim    <= '0;
            r_drv    <= 1'b0;
            r_sync   <= 1'b0;
            r_fault  <= 1'b0;
            r_vout_l <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_duty  <= w_duty_nxt;
            r_lim   <= w_lim_nxt;
            r_drv   <= w_drv_nxt;
            r_sync  <= w_period_end;
            r_fault <= (w_state_nxt == ST_FAULT);
            if (sample_valid) r_vout_l <= vout_sense;
        end
    end

    assign pfc_drv   = r_drv;
    assign duty      = r_duty;
    assign pwm_sync  = r_sync;
    assign state     = r_state;
    assign fault_ovp = r_fault;

endmodule

// File: tb/tb_pfc_boost_ctrl.sv
// Testbench for pfc_boost_ctrl: directed sequence with randomized sense values,
// expectations from a per-period arithmetic model of the duty rules.
module tb_pfc_boost_ctrl;

    localparam int VT      = 10066329;
    localparam int VOVP    = 11744051;
    localparam int BASE    = 80;
    localparam int DMAX    = 180;
    localparam int STEP    = 4;
    localparam int PERIOD  = 200;
    localparam int SS_PER  = DMAX / STEP;
`ifdef PFC_FEEDFORWARD_EN
    localparam bit FF_ON = 1'b1;
`else
    localparam bit FF_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        fault_clr;
    logic        sample_valid;
    logic [23:0] vin_sense;
    logic [23:0] vout_sense;
    logic        pfc_drv;
    logic [7:0]  duty;
    logic        pwm_sync;
    logic [1:0]  state;
    logic        fault_ovp;

    int total = 0;
    int bad   = 0;

    pfc_boost_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .fault_clr    (fault_clr),
        .sample_valid (sample_valid),
        .vin_sense    (vin_sense),
        .vout_sense   (vout_sense),
        .pfc_drv      (pfc_drv),
        .duty         (duty),
        .pwm_sync     (pwm_sync),
        .state        (state),
        .fault_ovp    (fault_ovp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_cmd(input longint vo, input longint vi);
        longint e;
        longint f;
        longint s;
        e = (vo < VT) ? ((VT - vo) / 65536) : 0;
        f = (vi < VT) ? ((VT - vi) / 131072) : 0;
        s = BASE + e + (FF_ON ? f : 0);
        if (s > DMAX) s = DMAX;
        return int'(s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_sync(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 2 * PERIOD && !found; i++) begin
            @(negedge clk);
            if (pwm_sync === 1'b1) found = 1'b1;
        end
        chk(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic sample(input int vo, input int vi);
        vout_sense   = 24'(vo);
        vin_sense    = 24'(vi);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
    endtask

    // Enable at a period start, then check each ramp step against min(cmd, k*STEP).
    task automatic soft_start(input int cmd);
        int lim;
        wait_sync("ss_align");
        en = 1'b1;
        for (int k = 1; k <= SS_PER; k++) begin
            wait_sync("ss_sync");
            lim = (k * STEP > DMAX) ? DMAX : k * STEP;
            chk("ss_duty", 32'(duty), 32'((cmd < lim) ? cmd : lim));
            chk("ss_state", 32'(state), (k < SS_PER) ? 32'd1 : 32'd2);
        end
    endtask

    // Called on a pwm_sync cycle: count gate-high clocks over one full period.
    task automatic period_drv(input int exp_high);
        int hi;
        hi = (pfc_drv === 1'b1) ? 1 : 0;
        for (int i = 1; i < PERIOD; i++) begin
            @(negedge clk);
            if (pfc_drv === 1'b1) hi++;
        end
        chk("drv_high_count", 32'(hi), 32'(exp_high));
    endtask

    initial begin
        int cur;
        int nvo;
        int nvi;
        int vin_a;

        rst_n        = 1'b0;
        en           = 1'b0;
        fault_clr    = 1'b0;
        sample_valid = 1'b0;
        vin_sense    = '0;
        vout_sense   = '0;
        cyc(2);
        chk("rst_drv",   32'(pfc_drv),   32'd0);
        chk("rst_duty",  32'(duty),      32'd0);
        chk("rst_sync",  32'(pwm_sync),  32'd0);
        chk("rst_state", 32'(state),     32'd0);
        chk("rst_fault", 32'(fault_ovp), 32'd0);
        rst_n = 1'b1;

        // Idle: stays put, ignores fault_clr, counter still runs.
        cyc(5);
        chk("idle_state", 32'(state), 32'd0);
        pulse_clr();
        chk("idle_clr_state", 32'(state), 32'd0);
        chk("idle_clr_fault", 32'(fault_ovp), 32'd0);
        wait_sync("idle_sync");
        chk("idle_duty", 32'(duty), 32'd0);
        chk("idle_drv", 32'(pfc_drv), 32'd0);

        // Soft start with vout=0: full ramp up to DUTY_MAX.
        vin_a = int'($urandom_range(0, 24'hFFFFFF));
        sample(0, vin_a);
        cur = exp_cmd(0, vin_a);
        soft_start(cur);
        period_drv(cur);

        // Mid-period sample changes apply only from the next period.
        for (int it = 0; it < 4; it++) begin
            if (it == 0) begin
                nvo = VT;
                nvi = 0;
            end else begin
                nvo = int'($urandom_range(0, VOVP - 1));
                nvi = int'($urandom_range(0, 24'hFFFFFF));
            end
            wait_sync("chg_sync0");
            chk("chg_duty_start", 32'(duty), 32'(cur));
            cyc(50);
            sample(nvo, nvi);
            chk("chg_duty_mid", 32'(duty), 32'(cur));
            cyc(PERIOD - 52);
            chk("chg_duty_late", 32'(duty), 32'(cur));
            chk("chg_nosync", 32'(pwm_sync), 32'd0);
            @(negedge clk);
            chk("chg_sync", 32'(pwm_sync), 32'd1);
            cur = exp_cmd(nvo, nvi);
            chk("chg_duty_new", 32'(duty), 32'(cur));
        end

        // Just below trip level, and an unqualified trip value, both keep RUN.
        sample(VOVP - 1, nvi);
        chk("ovp_below_state", 32'(state), 32'd2);
        chk("ovp_below_fault", 32'(fault_ovp), 32'd0);
        cur = exp_cmd(VOVP - 1, nvi);
        vout_sense = 24'(VOVP);
        @(negedge clk);
        chk("ovp_novalid_state", 32'(state), 32'd2);
        vout_sense = '0;

        // Trip at exactly V_OVP while the gate is on.
        wait_sync("ovp_sync");
        chk("ovp_pre_duty", 32'(duty), 32'(cur));
        cyc(10);
        chk("ovp_pre_drv", 32'(pfc_drv), 32'd1);
        sample(VOVP, nvi);
        chk("ovp_state", 32'(state), 32'd3);
        chk("ovp_fault", 32'(fault_ovp), 32'd1);
        chk("ovp_drv", 32'(pfc_drv), 32'd0);
        chk("ovp_duty", 32'(duty), 32'd0);
        pulse_clr();
        chk("clr_unsafe_state", 32'(state), 32'd3);
        chk("clr_unsafe_fault", 32'(fault_ovp), 32'd1);
        wait_sync("fault_sync");
        chk("fault_drv", 32'(pfc_drv), 32'd0);
        en = 1'b0;
        sample(0, nvi);
        chk("resample_state", 32'(state), 32'd3);
        pulse_clr();
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_fault", 32'(fault_ovp), 32'd0);

        // Nominal: vin = vout = target, regulation at DUTY_BASE.
        sample(VT, VT);
        cur = exp_cmd(VT, VT);
        soft_start(cur);
        period_drv(cur);

        // Asynchronous reset while the gate is high.
        wait_sync("rst_sync_align");
        cyc(30);
        chk("prerst_drv", 32'(pfc_drv), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_drv",   32'(pfc_drv),   32'd0);
        chk("arst_duty",  32'(duty),      32'd0);
        chk("arst_sync",  32'(pwm_sync),  32'd0);
        chk("arst_state", 32'(state),     32'd0);
        chk("arst_fault", 32'(fault_ovp), 32'd0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Latched samples were cleared by reset, so cmd follows vout=vin=0.
        cur = exp_cmd(0, 0);
        soft_start(cur);
        period_drv(cur);
        en = 1'b0;
        @(negedge clk);
        chk("run_off_state", 32'(state), 32'd0);
        chk("run_off_duty", 32'(duty), 32'd0);
        chk("run_off_drv", 32'(pfc_drv), 32'd0);

        // Disable during soft start.
        en = 1'b1;
        wait_sync("ss_off_sync1");
        wait_sync("ss_off_sync2");
        chk("ss_off_duty_pre", 32'(duty), 32'(2 * STEP));
        cyc(3);
        chk("ss_off_drv_pre", 32'(pfc_drv), 32'd1);
        en = 1'b0;
        @(negedge clk);
        chk("ss_off_state", 32'(state), 32'd0);
        chk("ss_off_drv", 32'(pfc_drv), 32'd0);
        chk("ss_off_duty", 32'(duty), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pfc_boost_ctrl.md
PFC_BOOST_CTRL -- requirements
Module: pfc_boost_ctrl

Interface
REQ-001 SHALL have parameter ADC_W, default 24: sense word width; full scale is 200 V.
REQ-002 SHALL have parameter PWM_W, default 8: duty and PWM counter width.
REQ-003 SHALL have parameter PWM_PERIOD, default 200: clocks per PWM period; must satisfy PWM_PERIOD <= 2^PWM_W - 1.
REQ-004 SHALL have parameter V_TARGET, default 10066329: 120 V output regulation point.
REQ-005 SHALL have parameter V_OVP, default 11744051: 140 V overvoltage trip level.
REQ-006 SHALL have parameters DUTY_BASE=80, DUTY_MAX=180, ERR_SHIFT=16, FF_SHIFT=17, SS_STEP=4.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port en, input, 1 bit: converter enable.
REQ-010 SHALL have port fault_clr, input, 1 bit: single-cycle fault clear request.
REQ-011 SHALL have port sample_valid, input, 1 bit: qualifies vin_sense and vout_sense.
REQ-012 SHALL have port vin_sense, input, ADC_W bits: rectified input voltage.
REQ-013 SHALL have port vout_sense, input, ADC_W bits: boost output voltage.
REQ-014 SHALL have port pfc_drv, output, 1 bit: registered boost switch gate drive.
REQ-015 SHALL have port duty, output, PWM_W bits: duty applied in the current period.
REQ-016 SHALL have port pwm_sync, output, 1 bit: one-clock pulse when the counter equals 0.
REQ-017 SHALL have port state, output, 2 bits: IDLE=0, SOFTSTART=1, RUN=2, FAULT=3.
REQ-018 SHALL have port fault_ovp, output, 1 bit: sticky overvoltage flag.

Function
REQ-019 PWM counter SHALL count 0..PWM_PERIOD-1 and wrap to 0; it runs in every state.
REQ-020 pfc_drv SHALL be registered (counter < duty) in SOFTSTART or RUN, and 0 in all other states.
REQ-021 duty SHALL update only when the counter equals PWM_PERIOD-1, so the new value applies from the next period; changes never occur mid-period.
REQ-022 On sample_valid=1, the block SHALL latch vin_sense and vout_sense; the duty command SHALL use only latched values.
REQ-023 Error term SHALL be (V_TARGET - vout_l) >> ERR_SHIFT if vout_l < V_TARGET, else 0; the computation is unsigned and ADC_W bits wide.
REQ-024 duty_cmd SHALL be DUTY_BASE + error term (+ feedforward term, per REQ-036), computed at ADC_W+1 bits, saturated to DUTY_MAX, then truncated to PWM_W bits.
REQ-025 IDLE -> SOFTSTART SHALL occur when en=1; the soft-start limit starts at 0.
REQ-026 In SOFTSTART, the limit SHALL increase by SS_STEP at each period end, saturating at DUTY_MAX; applied duty is min(duty_cmd, limit).
REQ-027 SOFTSTART -> RUN SHALL occur at the period end where the limit reaches DUTY_MAX.
REQ-028 In RUN, applied duty SHALL be duty_cmd.
REQ-029 From SOFTSTART or RUN, en=0 SHALL transition to IDLE on the next clock; duty then becomes 0 and pfc_drv 0.
REQ-030 In any state, a sample with vout_sense >= V_OVP SHALL transition to FAULT on the next clock, set fault_ovp=1, set pfc_drv=0, and set duty=0; OVP has priority over en and fault_clr.
REQ-031 FAULT -> IDLE SHALL occur only when fault_clr=1 and the latched vout < V_OVP; this also clears fault_ovp. A fault_clr outside FAULT SHALL be ignored.
REQ-032 Boundary: vout_l == V_TARGET SHALL give error 0; vout == V_OVP SHALL trip.

Reset
REQ-033 rst_n=0 SHALL asynchronously force: counter 0, duty 0, pfc_drv 0, pwm_sync 0, state IDLE, fault_ovp 0, latched samples 0, soft-start limit 0.
REQ-034 Reset asserted mid-period SHALL drop pfc_drv without waiting for a clock; after release, operation resumes from IDLE.

Configuration
REQ-035 Macro PFC_FEEDFORWARD_EN SHALL select whether input-voltage feedforward is compiled in.
REQ-036 With PFC_FEEDFORWARD_EN defined, duty_cmd SHALL add (V_TARGET - vin_l) >> FF_SHIFT when vin_l < V_TARGET, else 0. Without it, no feedforward term exists and vin_sense is unused.

Verification
REQ-037 en=1, vin=vout=10066329 held -> after soft start, RUN; duty=80; pfc_drv high 80 of every 200 clocks.
REQ-038 en=1, vout=0 -> limit 4, 8, ... 180; RUN entered at the end of period 45; duty=180 in RUN.
REQ-039 In RUN, sample vout=11744051 -> next clock: state=3, fault_ovp=1, pfc_drv=0; fault_clr with vout unchanged -> stays FAULT; resample vout=0 then fault_clr -> IDLE, fault_ovp=0.
REQ-040 In RUN, a vout change at counter=50 -> duty unchanged until counter wraps; the new duty is applied from the next pwm_sync.
REQ-041 rst_n pulled low at counter=30 while pfc_drv=1 -> pfc_drv=0 before the next clock edge; all outputs at reset values.
REQ-042 PFC_FEEDFORWARD_EN defined, vout=10066329, vin=0 -> duty=80+(10066329>>17)=156; undefined -> duty=80.
